// File: rtl/dct_pkg.sv
// Shared DCT constants, coefficient types and the DA engine state encoding.
package dct_pkg;

    typedef logic signed [15:0] coef_t;

    localparam coef_t C1 = 16'sd16069;
    localparam coef_t C2 = 16'sd15137;
    localparam coef_t C3 = 16'sd13623;
    localparam coef_t C4 = 16'sd11585;
    localparam coef_t C5 = 16'sd9102;
    localparam coef_t C6 = 16'sd6270;
    localparam coef_t C7 = 16'sd3196;

    // Row r, tap j lives at DCT4_COEF[r][j]
    localparam coef_t [0:3][0:3] DCT4_COEF = '{
        '{C4, C4, C4, C4},
        '{C1, C3, C5, C7},
        '{C2, C6, -C6, -C2},
        '{C3, -C7, -C1, -C5}
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_e;

endpackage

// File: rtl/da_lut.sv
// Distributed-arithmetic partial-sum table: one 2^TAPS-entry table per row,
// built at elaboration from the coefficient array.
module da_lut
    import dct_pkg::*;
#(
    parameter int TAPS  = 4,
    parameter int CW    = 16,
    parameter int NROWS = 4,
    parameter coef_t [0:NROWS-1][0:TAPS-1] COEF = DCT4_COEF,
    localparam int LW = CW + $clog2(TAPS),
    localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1
) (
    input  logic [RW-1:0]          row,
    input  logic [TAPS-1:0]        addr,
    output logic signed [LW-1:0]   L
);

    function automatic logic signed [LW-1:0] entry(int r, int a);
        logic signed [LW-1:0] s;
        s = '0;
        for (int j = 0; j < TAPS; j++) begin
            if (((a >> j) & 1) != 0) begin
                s = s + LW'(COEF[r][j]);
            end
        end
        return s;
    endfunction

    logic signed [LW-1:0] tbl [2**RW][2**TAPS];

    for (genvar gr = 0; gr < 2**RW; gr++) begin : g_row
        for (genvar ga = 0; ga < 2**TAPS; ga++) begin : g_addr
            if (gr < NROWS) begin : g_used
                assign tbl[gr][ga] = entry(gr, ga);
            end else begin : g_pad
                assign tbl[gr][ga] = '0;
            end
        end
    end

    assign L = tbl[row][addr];

endmodule

// File: rtl/da_dot_engine.sv
// Bit-serial DA inner-product engine: y = sum_j COEF[row][j] * x[j],
// one sample bit per cycle, sign bit subtracted last.
module da_dot_engine
    import dct_pkg::*;
#(
    parameter int TAPS  = 4,
    parameter int DW    = 8,
    parameter int CW    = 16,
    parameter int NROWS = 4,
    parameter int RSW   = (NROWS > 1) ? $clog2(NROWS) : 1,
    parameter coef_t [0:NROWS-1][0:TAPS-1] COEF = DCT4_COEF,
    localparam int ACCW = CW + $clog2(TAPS) + DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cs,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TAPS*DW-1:0]     x,
    input  logic [RSW-1:0]         row_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [ACCW-1:0] y,
    output logic                   row_err
);

    localparam int LW  = CW + $clog2(TAPS);
    localparam int LRW = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int BW  = $clog2(DW);

    state_e                 state_q, state_d;
    logic [TAPS*DW-1:0]     x_q, x_d;
    logic [LRW-1:0]         row_q, row_d;
    logic                   err_q, err_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic signed [ACCW-1:0] acc_q, acc_d;

    logic [TAPS-1:0]        addr;
    logic signed [LW-1:0]   lut_l;
    logic signed [ACCW-1:0] term;
    logic                   last, bad_row, accept;

    // A bad row behaves as an all-zero coefficient row
    always_comb begin
        addr = '0;
        for (int j = 0; j < TAPS; j++) begin
            addr[j] = x_q[j*DW + int'(bit_q)] & ~err_q;
        end
    end

    da_lut #(
        .TAPS  (TAPS),
        .CW    (CW),
        .NROWS (NROWS),
        .COEF  (COEF)
    ) u_lut (
        .row  (row_q),
        .addr (addr),
        .L    (lut_l)
    );

    assign last    = (bit_q == BW'(DW - 1));
    assign term    = ACCW'(lut_l) <<< bit_q;
    assign bad_row = (32'(row_sel) >= NROWS);

    assign in_ready  = rst_n & (state_q == ST_IDLE) & cs & ~abort;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign y         = out_valid ? acc_q : '0;
    assign row_err   = out_valid & err_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        row_d   = row_q;
        err_d   = err_q;
        bit_d   = bit_q;
        acc_d   = acc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    x_d     = x;
                    row_d   = bad_row ? '0 : row_sel[LRW-1:0];
                    err_d   = bad_row;
                    bit_d   = '0;
                    acc_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = last ? acc_q - term : acc_q + term;
                    bit_d = bit_q + 1'b1;
                    if (last) begin
                        bit_d   = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (abort || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
            bit_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            row_q   <= row_d;
            err_q   <= err_d;
            bit_q   <= bit_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_da_dot_engine.sv
// Directed bench for da_dot_engine with a transaction-level reference model.
module tb_da_dot_engine;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs = 1'b0;
    logic abort = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, row_err;
    logic [31:0] x = '0;
    logic [2:0] row_sel = '0;
    logic signed [25:0] y;

    always #5 clk = ~clk;

    da_dot_engine #(.RSW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .row_sel   (row_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .row_err   (row_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference coefficients, row r / tap j
    localparam int CT [4][4] = '{
        '{11585, 11585, 11585, 11585},
        '{16069, 13623, 9102, 3196},
        '{15137, 6270, -6270, -15137},
        '{13623, -3196, -16069, -9102}
    };

    // Transaction model: one pending result, due DW edges after acceptance
    bit     pending = 0;
    int     cyc = 0;
    int     due = 0;
    int     acc_cnt = 0;
    longint exp_y = 0;
    bit     exp_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending = 0;
        end else begin
            cyc++;
            if (pending && abort) begin
                pending = 0;
            end else if (pending && cyc > due && out_ready) begin
                pending = 0;
            end else if (!pending && cs && !abort && in_valid) begin
                pending = 1;
                due = cyc + DW;
                acc_cnt++;
                exp_y = 0;
                exp_err = (row_sel >= 3'd4);
                if (!exp_err) begin
                    for (int j = 0; j < 4; j++) begin
                        exp_y += longint'(CT[row_sel][j]) *
                                 longint'($signed(x[j*8 +: 8]));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        #1;
        if (rst_n) begin
            ev = pending && cyc >= due;
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, !pending && cs && !abort);
            if (ev) begin
                chk("y", y, exp_y);
                chk("row_err", row_err, exp_err);
            end
        end
    end

    task automatic send(int r, int x0, int x1, int x2, int x3);
        int c0;
        c0 = acc_cnt;
        row_sel = r[2:0];
        x = {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
        in_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (acc_cnt != c0) break;
        end
        chk("accept", acc_cnt, c0 + 1);
        in_valid = 1'b0;
    endtask

    task automatic expect_result(longint ly, bit le);
        int  n;
        bit  got;
        n = 0;
        got = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                got = 1;
                break;
            end
            n++;
            @(negedge clk);
        end
        chk("result_seen", got, 1);
        chk("model_y_lit", exp_y, ly);
        if (got) begin
            chk("latency", n, DW);
            chk("y_lit", y, ly);
            chk("row_err_lit", row_err, le);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int c0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_row_err", row_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cs = 1'b1;
        @(negedge clk);

        send(0, 1, 1, 1, 1);          expect_result(46340, 0);
        send(1, 1, 0, 0, 0);          expect_result(16069, 0);
        send(1, -1, 0, 0, 0);         expect_result(-16069, 0);
        send(0, -128, -128, -128, -128);
        expect_result(-5931520, 0);
        send(0, 127, 127, 127, 127);  expect_result(5885180, 0);

        // Backpressure with a second vector already waiting
        out_ready = 1'b0;
        send(3, 1, 2, 3, 4);
        expect_result(-77384, 0);
        row_sel = 3'd2;
        x = {8'd0, 8'd0, 8'd1, 8'd1};
        in_valid = 1'b1;
        repeat (5) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_y", y, -77384);
            chk("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(2, 1, 1, 0, 0);          expect_result(21407, 0);

        // Abort while bit 3 is being accumulated
        send(0, 1, 1, 1, 1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (12) begin
            chk("abort_no_valid", out_valid, 0);
            @(negedge clk);
        end
        send(2, 1, 1, 0, 0);          expect_result(21407, 0);

        send(5, 1, 1, 1, 1);          expect_result(0, 1);
        send(1, 0, 0, 0, 1);          expect_result(3196, 0);

        // cs low blocks acceptance
        cs = 1'b0;
        row_sel = 3'd0;
        in_valid = 1'b1;
        c0 = acc_cnt;
        repeat (5) begin
            @(negedge clk);
            chk("cs_in_ready", in_ready, 0);
        end
        chk("cs_no_accept", acc_cnt, c0);
        in_valid = 1'b0;
        cs = 1'b1;

        // abort in IDLE blocks a same-cycle request
        abort = 1'b1;
        in_valid = 1'b1;
        c0 = acc_cnt;
        repeat (2) @(negedge clk);
        chk("abort_idle_no_accept", acc_cnt, c0);
        abort = 1'b0;
        in_valid = 1'b0;

        // Reset mid-transaction discards everything
        send(0, 1, 1, 1, 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_y", y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            chk("midrst_no_valid", out_valid, 0);
            @(negedge clk);
        end
        send(2, 0, 0, 1, 1);          expect_result(-21407, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
